systolic_out_collector: RTL and testbench

Output-side collector for the `systolic_accu` PE array. It takes the skewed per-column partial sums streamed out of the array and de-skews them into a banked accumulator. Partial sums are summed across input-channel (K) tiles, and the clear-accumulator pulse is issued back to the array after each pass. After the final pass, it rescales every result by arithmetic right shift, saturates it to the activation width, and streams the int8 output matrix row-major over a valid/ready port.

---
 rtl/systolic_out_collector.sv | 166 ++++++++++++++++
 tb/tb_systolic_out_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_out_collector.sv
// De-skews array partial sums into banked accumulators (K-tile summed), then drains rescaled, saturated
// results row-major; output is registered (1 cycle), out_data/row/col held while out_valid && !out_ready.
module systolic_out_collector #(
  parameter int width   = 4,
  parameter int BW_ACCU = 32,
  parameter int BW_ACT  = 8,
  parameter int ROWS    = 100,
  parameter int COLS    = 16,
  localparam int NBLK   = COLS / width,
  localparam int CBW    = $clog2(NBLK + 1),
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CBW-1:0]           col_blk,
  input  logic                     first,
  input  logic                     last,
  input  logic [7:0]               shift_num,
  input  logic [width*BW_ACCU-1:0] res_in,
  input  logic                     res_valid,
  output logic                     busy,
  output logic                     clear_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BW_ACT-1:0]        out_data,
  output logic [RW-1:0]            out_row,
  output logic [CW-1:0]            out_col,
  output logic                     done,
  output logic                     err
);

  localparam int SW = $clog2(ROWS + width);
  localparam int AW = (ROWS * NBLK > 1) ? $clog2(ROWS * NBLK) : 1;
  localparam int LW = (width > 1) ? $clog2(width) : 1;
  localparam logic signed [BW_ACCU-1:0] ACT_MAX = BW_ACCU'(2 ** (BW_ACT - 1) - 1);
  localparam logic signed [BW_ACCU-1:0] ACT_MIN = ~ACT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CLEAR, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    s_q;
  logic [CBW-1:0]   blk_q;
  logic             first_q, last_q;
  logic [7:0]       shift_q;
  logic             legal_blk, handshake, last_ptr;
  int               nr, nc;
  logic [AW-1:0]    rd_addr;
  logic [LW-1:0]    rd_lane;
  logic [BW_ACCU-1:0] bank_rd [width];

  function automatic logic [BW_ACT-1:0] sat(input logic [BW_ACCU-1:0] a, input logic [7:0] sh);
    logic signed [BW_ACCU-1:0] v;
    if (int'(sh) >= BW_ACCU) v = {BW_ACCU{a[BW_ACCU-1]}};
    else                     v = $signed(a) >>> sh;
    if (v < ACT_MIN)      return {1'b1, {(BW_ACT-1){1'b0}}};
    else if (v > ACT_MAX) return {1'b0, {(BW_ACT-1){1'b1}}};
    else                  return v[BW_ACT-1:0];
  endfunction

  assign legal_blk = (col_blk < CBW'(NBLK));
  assign handshake = out_valid && out_ready;
  assign last_ptr  = (out_row == RW'(ROWS - 1)) && (out_col == CW'(COLS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    clear_acc = (state_q == S_CLEAR);
    case (state_q)
      S_IDLE:    if (start && legal_blk) state_d = S_COLLECT;
      S_COLLECT: if (res_valid && s_q == SW'(ROWS + width - 2)) state_d = S_CLEAR;
      S_CLEAR:   state_d = last_q ? S_DRAIN : S_IDLE;
      S_DRAIN:   if (handshake && last_ptr) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next drain pointer: (0,0) when entering DRAIN, else one step row-major.
  always_comb begin
    nr = int'(out_row);
    nc = int'(out_col) + 1;
    if (state_q != S_DRAIN) begin
      nr = 0;
      nc = 0;
    end else if (nc == COLS) begin
      nc = 0;
      nr = (nr == ROWS - 1) ? 0 : nr + 1;
    end
    rd_addr = AW'(nr * NBLK + nc / width);
    rd_lane = LW'(nc % width);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q       <= '0;
      blk_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      shift_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          if (legal_blk) begin
            blk_q   <= col_blk;
            first_q <= first;
            last_q  <= last;
            shift_q <= shift_num;
            s_q     <= '0;
          end else begin
            err <= 1'b1;
          end
        end
        S_COLLECT: if (res_valid) s_q <= s_q + SW'(1);
        S_CLEAR: if (last_q) begin
          out_valid <= 1'b1;
          out_row   <= '0;
          out_col   <= '0;
          out_data  <= sat(bank_rd[rd_lane], shift_q);
        end
        S_DRAIN: if (handshake) begin
          if (last_ptr) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
          end else begin
            out_row  <= RW'(nr);
            out_col  <= CW'(nc);
            out_data <= sat(bank_rd[rd_lane], shift_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Bank p holds column blk*width+p; lane p sees output row s-p on skew step s.
  for (genvar p = 0; p < width; p++) begin : g_bank
    logic [BW_ACCU-1:0] mem [ROWS*NBLK];
    logic               in_win;
    logic [AW-1:0]      wa;

    assign in_win = (int'(s_q) >= p) && (int'(s_q) <= p + ROWS - 1);
    assign wa     = AW'((int'(s_q) - p) * NBLK + int'(blk_q));

    always_ff @(posedge clk) begin
      if (state_q == S_COLLECT && res_valid && in_win)
        mem[wa] <= (first_q ? '0 : mem[wa]) + res_in[p*BW_ACCU +: BW_ACCU];
    end

    assign bank_rd[p] = mem[rd_addr];
  end

endmodule

// File: tb/tb_systolic_out_collector.sv
// Scoreboarded bench for systolic_out_collector at ROWS=4, COLS=8, width=4.
module tb_systolic_out_collector;

  logic         clk = 0;
  logic         reset;
  logic         start;
  logic [1:0]   col_blk;
  logic         first, last;
  logic [7:0]   shift_num;
  logic [127:0] res_in;
  logic         res_valid;
  logic         busy, clear_acc, out_valid, out_ready, done, err;
  logic [7:0]   out_data;
  logic [1:0]   out_row;
  logic [2:0]   out_col;

  systolic_out_collector #(.width(4), .BW_ACCU(32), .BW_ACT(8), .ROWS(4), .COLS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .col_blk(col_blk), .first(first), .last(last),
    .shift_num(shift_num), .res_in(res_in), .res_valid(res_valid), .busy(busy),
    .clear_acc(clear_acc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int row; int col; int data;} exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;
  int hs_cnt = 0, ov_cnt = 0, clr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int collect_len = 0, run_len = 0;
  bit busy_prev = 0;
  int gap_tab [7] = '{1, 0, 2, 3, 0, 1, 2};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and keeps event counters.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) check("extra_output", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("out_row", int'(out_row), e.row);
          check("out_col", int'(out_col), e.col);
          check("out_data", int'($signed(out_data)), e.data);
        end
      end
      if (out_valid) ov_cnt++;
      if (done) begin
        done_cnt++;
        check("done_busy_low", int'(busy), 0);
      end
      if (err) err_cnt++;
      if (busy && !busy_prev) run_len = 1;
      else if (busy && !clear_acc) run_len++;
      if (clear_acc) begin
        clr_cnt++;
        collect_len = run_len;
      end
    end
    busy_prev = busy;
  end

  function automatic logic [31:0] lane_val(input int val, input bit skew, input int s, input int p);
    if (skew && ((p == 3 && s <= 2) || (p == 0 && s >= 4))) return 32'h7FFF_FFFF;
    return val;
  endfunction

  // exp0/exp1: hand-computed drained value of column blocks 0 and 1.
  task automatic run_pass(input int blk, input bit f, input bit l, input int sh, input int val,
                          input bit skew, input bit gaps, input bit hold, input int exp0, input int exp1);
    int hs0, ov0, clr0, dn0, gtot;
    bit held;
    hs0 = hs_cnt; ov0 = ov_cnt; clr0 = clr_cnt; dn0 = done_cnt; gtot = 0; held = 0;
    if (l)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 8; c++) sb.push_back('{r, c, (c < 4) ? exp0 : exp1});
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);
    start = 1; col_blk = 2'(blk); first = f; last = l; shift_num = 8'(sh);
    @(posedge clk); #1;
    start = 0;
    check("busy_rise", int'(busy), 1);
    for (int s = 0; s < 7; s++) begin
      if (gaps) begin
        res_valid = 0;
        repeat (gap_tab[s]) begin @(posedge clk); #1; end
        gtot += gap_tab[s];
      end
      res_valid = 1;
      for (int p = 0; p < 4; p++) res_in[p*32 +: 32] = lane_val(val, skew, s, p);
      @(posedge clk); #1;
    end
    res_valid = 0;
    res_in = '1;
    if (l) begin
      for (int i = 0; i < 300 && done_cnt == dn0; i++) begin
        @(posedge clk); #1;
        if (hold && !held && out_valid && out_row == 2 && out_col == 3) begin
          held = 1;
          out_ready = 0;
          repeat (5) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_row", int'(out_row), 2);
            check("hold_col", int'(out_col), 3);
            check("hold_data", int'($signed(out_data)), exp0);
            @(posedge clk); #1;
          end
          out_ready = 1;
        end
      end
      check("done_pulses", done_cnt - dn0, 1);
      check("handshakes", hs_cnt - hs0, 32);
      check("drain_cycles", ov_cnt - ov0, hold ? 37 : 32);
    end else begin
      repeat (2) begin @(posedge clk); #1; end
      check("pass_end_busy", int'(busy), 0);
    end
    check("clear_pulses", clr_cnt - clr0, 1);
    check("collect_len", collect_len, 7 + gtot);
  endtask

  initial begin
    reset = 0; start = 0; col_blk = 0; first = 0; last = 0; shift_num = 0;
    res_in = '0; res_valid = 0; out_ready = 1;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_clear", int'(clear_acc), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_row", int'(out_row), 0);
    check("rst_col", int'(out_col), 0);
    @(posedge clk); #1 reset = 1;

    // blk1 := 0, then single pass 256 >> 8 on blk0
    run_pass(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_pass(0, 1, 1, 8, 256, 0, 0, 0, 1, 0);
    // K-tile accumulation and saturation: blk0 raw 256
    run_pass(1, 1, 0, 0, 100, 0, 0, 0, 0, 0);
    run_pass(1, 0, 1, 0, 200, 0, 0, 0, 127, 127);
    run_pass(1, 1, 0, 0, -100, 0, 0, 0, 0, 0);
    run_pass(1, 0, 1, 0, -200, 0, 0, 0, 127, -128);
    // shift beyond width: 256 -> 0, -300 -> -1
    run_pass(0, 1, 1, 40, 256, 0, 0, 0, 0, -1);
    run_pass(1, 1, 0, 0, 30, 0, 0, 0, 0, 0);
    run_pass(1, 0, 1, 1, 20, 0, 0, 0, 127, 25);
    // out-of-window garbage must not land: 512 >> 9 = 1, blk1 50 >> 9 = 0
    run_pass(0, 1, 1, 9, 512, 1, 0, 0, 1, 0);
    // res_valid gaps plus backpressure at (2,3)
    run_pass(0, 1, 1, 8, 256, 0, 1, 1, 1, 0);

    // reset in the middle of COLLECT
    begin
      int clr0;
      clr0 = clr_cnt;
      @(posedge clk); #1;
      start = 1; col_blk = 0; first = 1; last = 1; shift_num = 0;
      @(posedge clk); #1;
      start = 0;
      repeat (3) begin
        res_valid = 1; res_in = {4{32'd7}};
        @(posedge clk); #1;
      end
      check("mid_busy", int'(busy), 1);
      reset = 0;
      #1;
      check("rstmid_busy", int'(busy), 0);
      check("rstmid_valid", int'(out_valid), 0);
      check("rstmid_clear", int'(clear_acc), 0);
      res_valid = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1;
      repeat (3) begin @(posedge clk); #1; end
      check("rstmid_no_clear", clr_cnt - clr0, 0);
      check("rstmid_idle", int'(busy), 0);
    end

    // illegal column block
    begin
      int e0;
      e0 = err_cnt;
      @(posedge clk); #1;
      start = 1; col_blk = 2; first = 1; last = 1;
      @(posedge clk); #1;
      start = 0;
      check("err_pulse", int'(err), 1);
      check("err_busy", int'(busy), 0);
      @(posedge clk); #1;
      check("err_one_cycle", int'(err), 0);
      check("err_still_idle", int'(busy), 0);
      check("err_count", err_cnt - e0, 1);
    end

    // recovery after reset: restart blk0 with first=1
    run_pass(0, 1, 1, 8, 256, 0, 0, 0, 1, 0);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
